rng_word_scheduler: RTL and testbench
=====================================

Name: rng_word_scheduler

Overview:
- Sequences and shares the 64-bit LUT-SR random-bit generator among N consumers.
- Owns the generator's clock enable: flushes the generator after reset with a warm-up run, then hands out one fresh 64-bit word per grant under round-robin arbitration.
- Sits between the generator instance and the dither / noise-injection consumers in the channel datapath.

Parameters:
- N, 4, number of requesters (1..16).
- WARMUP, 64, generator ce pulses issued after reset before any word is delivered (1..65535).
- IDW, derived, max(1, clog2(N)); localparam, not overridable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  master run enable.
- req  in  N  per-requester word request; level, held until granted.
- gnt  out  N  one-hot grant; combinational from state, req and pointer.
- rng_ce  out  1  clock enable to the generator.
- rng_data  in  64  generator output; updates on the edge after rng_ce=1.
- out_valid  out  1  registered one-cycle strobe: word delivered.
- out_id  out  IDW  index of the requester receiving out_data.
- out_data  out  64  delivered random word.
- warm_done  out  1  warm-up complete; sticky until reset.

Behaviour:
- Reset (async, rst_n=0): state=WARM, warm counter=0, rr pointer=0, warm_done=0, out_valid=0, out_id=0, out_data=0. rng_ce=0 and gnt=0 while reset is held.
- States: WARM, SERVE. No return to WARM except via reset.
- WARM:
  - rng_ce = enable.
  - Counter increments on each cycle with rng_ce=1.
  - When the counter reaches WARMUP on a pulse, move to SERVE next cycle and set warm_done=1 on the same edge.
  - gnt=0 throughout WARM.
  - enable=0 pauses: ce low, counter holds.
- SERVE:
  - With enable=0 or req=0: gnt=0, rng_ce=0, out_valid=0 next cycle.
  - Otherwise gnt is one-hot to the first asserted req at or after the rr pointer, searching upward with wrap N-1 -> 0.
  - Grant cycle: rng_ce=1. out_data<=rng_data, out_id<=granted index, out_valid<=1, pointer<=(granted index+1) mod N.
  - rng_data refreshes on the next edge, so back-to-back grants (one per cycle) each receive a distinct generator word. No word is ever delivered twice.
  - Exactly one rng_ce pulse per grant; the generator never free-runs in SERVE.
- out_valid is high only on the cycle after a grant. out_data/out_id hold their last values otherwise.
- Requester dropping req without a grant: no effect, pointer unchanged.
- Reset mid-operation: immediate return to reset values. Warm-up restarts from 0 after release.
- N=1: arbitration degenerates to gnt[0]=req[0]; out_id stays 0.

Optional Feature:
- Macro RNG_WORD_COUNT_EN adds output word_count[31:0].
- word_count is reset to 0 and increments on every out_valid, wrapping at 2^32-1 -> 0.
- Without the macro the port and counter are absent; all other behaviour is identical.

Test Plan:
- Bench model: rng_data is a counter that increments on rng_ce. Default config N=4, WARMUP=64 unless stated.
- Release reset, enable=1, req=0 -> rng_ce high exactly 64 consecutive cycles, warm_done=1 after the 64th pulse, rng_ce=0 thereafter, gnt=0 throughout.
- After warm-up, req=4'b0101 held -> gnt 0001,0100,0001,0100 each cycle; out_valid=1 continuously one cycle later; out_id 0,2,0,2; out_data 64,65,66,67 (counter model).
- Warm-up with enable dropped at pulse 30 for 10 cycles -> rng_ce=0 during the gap, 34 further pulses after re-enable, warm_done after 64 total.
- SERVE, pointer=3, req=4'b1001 -> gnt=1000 then 0001; single req=4'b0010 -> gnt=0010 every cycle, pointer=2 after each.
- rst_n low for 1 cycle mid-SERVE with req=4'b1111 -> gnt, rng_ce, out_valid, warm_done drop to 0 without a clock edge; after release, 64-pulse warm-up repeats before any grant.
- RNG_WORD_COUNT_EN defined, 5 grants issued -> word_count=5; forced to 32'hFFFFFFFF then one grant -> 0.

Source files
------------

// File: rtl/rng_word_scheduler.sv
// rng_word_scheduler: warms up and shares a 64-bit random-bit generator
// among N requesters, one fresh word per round-robin grant.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     master run enable
//   req[N]     level requests, held until granted
//   gnt[N]     one-hot grant (combinational)
//   rng_ce     generator clock enable
//   rng_data   generator output word
//   out_valid  one-cycle strobe: word delivered
//   out_id     requester index of delivered word
//   out_data   delivered word
//   warm_done  sticky warm-up complete flag
//   word_count delivered word counter (only with RNG_WORD_COUNT_EN)
//
// Optional feature macro: RNG_WORD_COUNT_EN

module rng_word_scheduler #(
    parameter int N      = 4,
    parameter int WARMUP = 64,
    localparam int IDW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           rng_ce,
    input  logic [63:0]    rng_data,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic [63:0]    out_data,
    output logic           warm_done
`ifdef RNG_WORD_COUNT_EN
    ,
    output logic [31:0]    word_count
`endif
);

    typedef enum logic {
        WARM  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t         r_state;
    logic [15:0]    r_warm_cnt;
    logic [IDW-1:0] r_ptr;
    logic           r_warm_done;
    logic           r_out_valid;
    logic [IDW-1:0] r_out_id;
    logic [63:0]    r_out_data;

    logic [N-1:0]   w_sel;
    logic [IDW-1:0] w_sel_idx;
    logic           w_hit;
    logic           w_grant;
    logic [IDW-1:0] w_ptr_nxt;
    int             w_pos;

    // Round-robin search: first request at or after r_ptr, wrapping.
    always_comb begin
        w_sel     = '0;
        w_sel_idx = '0;
        w_hit     = 1'b0;
        w_pos     = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!w_hit && req[w_pos[IDW-1:0]]) begin
                w_hit     = 1'b1;
                w_sel_idx = w_pos[IDW-1:0];
            end
        end
        if (w_hit) begin
            w_sel[w_sel_idx] = 1'b1;
        end
    end

    assign w_grant = (r_state == SERVE) && enable && w_hit;

    assign w_ptr_nxt = (w_sel_idx == IDW'(N - 1))
                     ? '0
                     : w_sel_idx + 1'b1;

    assign gnt = w_grant ? w_sel : '0;

    // Generator only runs during warm-up or for a grant; the rst_n gate
    // keeps it quiet while reset is held even with enable high.
    assign rng_ce = rst_n &&
                    ((r_state == WARM) ? enable : w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WARM;
            r_warm_cnt  <= '0;
            r_ptr       <= '0;
            r_warm_done <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_out_data  <= '0;
        end else begin
            unique case (r_state)
                WARM: begin
                    r_out_valid <= 1'b0;
                    if (enable) begin
                        r_warm_cnt <= r_warm_cnt + 16'd1;
                        if (r_warm_cnt == 16'(WARMUP - 1)) begin
                            r_state     <= SERVE;
                            r_warm_done <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    r_out_valid <= w_grant;
                    if (w_grant) begin
                        // rng_data still holds the word not yet handed
                        // out; this grant's ce pulse advances it.
                        r_out_data <= rng_data;
                        r_out_id   <= w_sel_idx;
                        r_ptr      <= w_ptr_nxt;
                    end
                end
                default: begin
                    r_state <= WARM;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_data  = r_out_data;
    assign warm_done = r_warm_done;

`ifdef RNG_WORD_COUNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
        end else if (r_out_valid) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_rng_word_scheduler.sv
// tb_rng_word_scheduler: vector table, directed corner sequences and
// randomized traffic checked against a behavioural scheduler model.

module tb_rng_word_scheduler;

    localparam int N      = 4;
    localparam int WARMUP = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         rng_ce;
    logic [63:0]  rng_data;
    logic         out_valid;
    logic [1:0]   out_id;
    logic [63:0]  out_data;
    logic         warm_done;
`ifdef RNG_WORD_COUNT_EN
    logic [31:0]  word_count;
    logic [31:0]  m_wc;
`endif

    logic [63:0]  gen_cnt = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int           m_pulses;
    bit           m_wd;
    int           m_ptr;
    bit           m_ov;
    int           m_id;
    logic [63:0]  m_data;

    // values observed at the last sampling point
    logic [N-1:0] o_gnt;
    logic         o_ce;
    logic         o_ov;
    logic [1:0]   o_id;
    logic [63:0]  o_data;

    rng_word_scheduler #(
        .N(N),
        .WARMUP(WARMUP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .req(req),
        .gnt(gnt),
        .rng_ce(rng_ce),
        .rng_data(rng_data),
        .out_valid(out_valid),
        .out_id(out_id),
        .out_data(out_data),
        .warm_done(warm_done)
`ifdef RNG_WORD_COUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    // generator stand-in: counter advancing on each ce
    always @(posedge clk) begin
        if (rng_ce) gen_cnt <= gen_cnt + 64'd1;
    end
    assign rng_data = gen_cnt;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pulses = 0;
        m_wd     = 1'b0;
        m_ptr    = 0;
        m_ov     = 1'b0;
        m_id     = 0;
        m_data   = '0;
`ifdef RNG_WORD_COUNT_EN
        m_wc     = '0;
`endif
    endtask

    // One clock: apply inputs, check at negedge, advance model at posedge.
    task automatic cycle(input logic en, input logic [N-1:0] rq);
        int           gi;
        int           j;
        logic [N-1:0] eg;
        logic         ec;
        logic [63:0]  cap;
        enable = en;
        req    = rq;
        gi     = -1;
        eg     = '0;
        if (rst_n && m_pulses >= WARMUP && en) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (gi < 0 && rq[j]) gi = j;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        ec = rst_n && ((m_pulses < WARMUP) ? en : (gi >= 0));
        @(negedge clk);
        o_gnt  = gnt;
        o_ce   = rng_ce;
        o_ov   = out_valid;
        o_id   = out_id;
        o_data = out_data;
        cap    = gen_cnt;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("rng_ce", 64'(rng_ce), 64'(ec));
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_id", 64'(out_id), 64'(m_id));
        chk("out_data", out_data, m_data);
        chk("warm_done", 64'(warm_done), 64'(m_wd));
`ifdef RNG_WORD_COUNT_EN
        chk("word_count", 64'(word_count), 64'(m_wc));
`endif
        @(posedge clk);
        if (rst_n) begin
`ifdef RNG_WORD_COUNT_EN
            if (m_ov) m_wc = m_wc + 32'd1;
`endif
            if (m_pulses < WARMUP) begin
                m_ov = 1'b0;
                if (en) begin
                    m_pulses++;
                    if (m_pulses == WARMUP) m_wd = 1'b1;
                end
            end else begin
                m_ov = (gi >= 0);
                if (gi >= 0) begin
                    m_id   = gi;
                    m_data = cap;
                    m_ptr  = (gi + 1) % N;
                end
            end
        end
        #1;
    endtask

    typedef struct {
        logic         en;
        logic [N-1:0] rq;
        logic [N-1:0] g;
        logic         ce;
        logic         ov;
        logic [1:0]   id;
        logic [63:0]  d;
    } vec_t;

    vec_t tv[12];

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int gap_ce;
        int waits;
        bit seen;

        tv[0]  = '{1'b1, 4'b0101, 4'b0001, 1'b1, 1'b0, 2'd0, 64'd0};
        tv[1]  = '{1'b1, 4'b0101, 4'b0100, 1'b1, 1'b1, 2'd0, 64'd64};
        tv[2]  = '{1'b1, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd2, 64'd65};
        tv[3]  = '{1'b1, 4'b0101, 4'b0100, 1'b1, 1'b1, 2'd0, 64'd66};
        tv[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 64'd67};
        tv[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 64'd67};
        tv[6]  = '{1'b1, 4'b1001, 4'b1000, 1'b1, 1'b0, 2'd2, 64'd67};
        tv[7]  = '{1'b1, 4'b1001, 4'b0001, 1'b1, 1'b1, 2'd3, 64'd68};
        tv[8]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd0, 64'd69};
        tv[9]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 64'd70};
        tv[10] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 64'd71};
        tv[11] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1, 64'd71};

        // reset held: everything quiet even with enable and requests
        model_reset();
        rst_n = 1'b0;
        repeat (2) cycle(1'b1, '1);
        rst_n = 1'b1;

        // warm-up with no requests
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            cycle(1'b1, '0);
            if (o_ce) pulses++;
        end
        chk("warm_pulses", 64'(pulses), 64'd64);
        chk("warm_done_set", 64'(warm_done), 64'd1);

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            cycle(tv[i].en, tv[i].rq);
            chk($sformatf("tv%0d_gnt", i), 64'(o_gnt), 64'(tv[i].g));
            chk($sformatf("tv%0d_ce", i), 64'(o_ce), 64'(tv[i].ce));
            chk($sformatf("tv%0d_ov", i), 64'(o_ov), 64'(tv[i].ov));
            chk($sformatf("tv%0d_id", i), 64'(o_id), 64'(tv[i].id));
            chk($sformatf("tv%0d_data", i), o_data, tv[i].d);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 5) != 0, N'($urandom));
        end

        // warm-up paused by enable
        rst_n = 1'b0;
        model_reset();
        cycle(1'b1, '0);
        rst_n = 1'b1;
        pulses = 0;
        gap_ce = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, '0);
            if (o_ce) pulses++;
        end
        chk("pause_first30", 64'(pulses), 64'd30);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0);
            if (o_ce) gap_ce++;
        end
        chk("pause_gap_ce", 64'(gap_ce), 64'd0);
        chk("pause_not_done", 64'(warm_done), 64'd0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, '0);
            if (o_ce) pulses++;
        end
        chk("pause_rest", 64'(pulses), 64'd34);
        chk("pause_done", 64'(warm_done), 64'd1);

        // reset in the middle of serving all requesters
        repeat (3) cycle(1'b1, '1);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 64'(gnt), 64'd0);
        chk("arst_ce", 64'(rng_ce), 64'd0);
        chk("arst_ov", 64'(out_valid), 64'd0);
        chk("arst_wd", 64'(warm_done), 64'd0);
        model_reset();
        #1;
        cycle(1'b1, '1);
        rst_n = 1'b1;
        waits = 0;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle(1'b1, '1);
            if (o_gnt != '0) seen = 1'b1;
            else waits++;
        end
        chk("rewarm_seen_gnt", 64'(seen), 64'd1);
        chk("rewarm_delay", 64'(waits), 64'd64);
        repeat (20) cycle(1'b1, N'($urandom));

`ifdef RNG_WORD_COUNT_EN
        repeat (2) cycle(1'b1, '0);
        force dut.r_word_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_word_count;
        m_wc = 32'hFFFF_FFFF;
        cycle(1'b1, 4'b0001);
        cycle(1'b1, '0);
        cycle(1'b1, '0);
        chk("wc_wrap", 64'(word_count), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
